// File: rtl/vga_counter_bank_pkg.sv
// Shared defaults and helpers for the VGA counter bank.
package vga_counter_pkg;

    localparam int DEF_N_CH     = 16;
    localparam int DEF_WIDTH    = 16;
    localparam int DEF_TICK_DIV = 100_000_000;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

    // Channel 0 sits in the MSBs of the packed display bus.
    function automatic int ch_offset(input int n_ch, input int width, input int ch);
        return (n_ch - 1 - ch) * width;
    endfunction

endpackage

// File: rtl/vga_counter_bank_if.sv
// Load strobe and frame-snapshot bus between control logic, the counter bank
// and the text renderer.
interface vga_counter_bank_if
    import vga_counter_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int WIDTH = DEF_WIDTH
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                    load_valid;
    logic [CH_W-1:0]         load_ch;
    logic [WIDTH-1:0]        load_value;
    logic [N_CH*WIDTH-1:0]   data_raw;
    logic                    snap_valid;

    modport master (
        output load_valid, load_ch, load_value,
        input  data_raw, snap_valid
    );

    modport slave (
        input  load_valid, load_ch, load_value,
        output data_raw, snap_valid
    );

endinterface

// File: rtl/vga_counter_bank_counter_channel.sv
// One counter channel: clear > load > tick step, wrap detection and sticky ovf.
// Define VGA_COUNTER_BANK_BCD_EN for packed-BCD counting instead of binary.
module counter_channel
    import vga_counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             en,
    input  logic             down,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             ovf
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] load_norm;
    logic [WIDTH-1:0] step_val;
    logic             wrap;

`ifdef VGA_COUNTER_BANK_BCD_EN
    localparam int DIGITS = WIDTH / 4;

    logic       carry;
    logic [3:0] dig;

    // Ripple a carry/borrow through the digits; one left over means the whole
    // channel wrapped.
    always_comb begin
        load_norm = load_value;
        step_val  = count_q;
        carry     = 1'b1;
        dig       = '0;
        for (int d = 0; d < DIGITS; d++) begin
            dig = count_q[4*d +: 4];
            if (load_value[4*d +: 4] > BCD_DIGIT_MAX) begin
                load_norm[4*d +: 4] = BCD_DIGIT_MAX;
            end
            if (carry) begin
                if (down) begin
                    if (dig == 4'd0) begin
                        step_val[4*d +: 4] = BCD_DIGIT_MAX;
                    end else begin
                        step_val[4*d +: 4] = dig - 4'd1;
                        carry              = 1'b0;
                    end
                end else begin
                    if (dig >= BCD_DIGIT_MAX) begin
                        step_val[4*d +: 4] = 4'd0;
                    end else begin
                        step_val[4*d +: 4] = dig + 4'd1;
                        carry              = 1'b0;
                    end
                end
            end
        end
        wrap = carry;
    end
`else
    always_comb begin
        load_norm = load_value;
        step_val  = down ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
        wrap      = down ? (count_q == '0) : (count_q == '1);
    end
`endif

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            count_d = load_norm;
        end else if (tick && en) begin
            count_d = step_val;
            if (wrap) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/vga_counter_bank.sv
// Bank of N_CH timer/counter channels on a shared prescaled tick, snapshotted
// onto data_raw once per frame at the vsync falling edge.
// Optional build macro: VGA_COUNTER_BANK_BCD_EN (packed-BCD channels).
module vga_counter_bank
    import vga_counter_pkg::*;
#(
    parameter int N_CH     = DEF_N_CH,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                vsync,
    input  logic                clear,
    input  logic [N_CH-1:0]     ch_en,
    input  logic [N_CH-1:0]     ch_down,
    output logic [N_CH-1:0]     ovf,
    vga_counter_bank_if.slave   bus
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]          presc_q, presc_d;
    logic                   tick;
    logic                   vsync_q, vsync_prev_q, seen_high_q;
    logic                   seen_high_d;
    logic                   vsync_fall;
    logic [N_CH*WIDTH-1:0]  data_raw_q, data_raw_d;
    logic                   snap_valid_q, snap_valid_d;
    logic [WIDTH-1:0]       count [N_CH];

    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = presc_q + PW'(1);
        if (clear || tick) begin
            presc_d = '0;
        end
    end

    // seen_high blocks a fake edge when vsync is already low as reset releases.
    assign seen_high_d = seen_high_q | vsync;
    assign vsync_fall  = vsync_prev_q & ~vsync_q & seen_high_q;

    always_comb begin
        data_raw_d   = data_raw_q;
        snap_valid_d = vsync_fall;
        if (vsync_fall) begin
            for (int i = 0; i < N_CH; i++) begin
                data_raw_d[ch_offset(N_CH, WIDTH, i) +: WIDTH] = count[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q      <= '0;
            vsync_q      <= 1'b1;
            vsync_prev_q <= 1'b1;
            seen_high_q  <= 1'b0;
            data_raw_q   <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            vsync_q      <= vsync;
            vsync_prev_q <= vsync_q;
            seen_high_q  <= seen_high_d;
            data_raw_q   <= data_raw_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        counter_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .en         (ch_en[g]),
            .down       (ch_down[g]),
            .clear      (clear),
            .load       (bus.load_valid && (bus.load_ch == CH_W'(g))),
            .load_value (bus.load_value),
            .count      (count[g]),
            .ovf        (ovf[g])
        );
    end

    assign bus.data_raw   = data_raw_q;
    assign bus.snap_valid = snap_valid_q;

endmodule

// File: tb/tb_vga_counter_bank.sv
// Scoreboard bench for vga_counter_bank: 4 channels x 16 bits, tick every 4 cycles.
module tb_vga_counter_bank;

    localparam int N_CH     = 4;
    localparam int WIDTH    = 16;
    localparam int TICK_DIV = 4;

`ifdef VGA_COUNTER_BANK_BCD_EN
    localparam logic [15:0] MAXV = 16'h9999;
`else
    localparam logic [15:0] MAXV = 16'hFFFF;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            vsync;
    logic            clear;
    logic [N_CH-1:0] ch_en;
    logic [N_CH-1:0] ch_down;
    logic [N_CH-1:0] ovf;

    int tests     = 0;
    int fails     = 0;
    int snap_seen = 0;
    int pushed    = 0;

    logic [63:0] exp_q[$];

    vga_counter_bank_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus_if ();

    vga_counter_bank #(
        .N_CH     (N_CH),
        .WIDTH    (WIDTH),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .vsync   (vsync),
        .clear   (clear),
        .ch_en   (ch_en),
        .ch_down (ch_down),
        .ovf     (ovf),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic load(input int ch, input logic [15:0] val);
        bus_if.load_valid = 1'b1;
        bus_if.load_ch    = 2'(ch);
        bus_if.load_value = val;
        cyc();
        bus_if.load_valid = 1'b0;
    endtask

    task automatic expect_snap(input logic [63:0] exp);
        exp_q.push_back(exp);
        pushed++;
    endtask

    task automatic snap(input logic [63:0] exp);
        expect_snap(exp);
        vsync = 1'b0;
        cycles(2);
        vsync = 1'b1;
        cycles(2);
        chk("snap_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic run_en(input logic [N_CH-1:0] en, input int n);
        ch_en = en;
        cycles(n);
        ch_en = '0;
    endtask

    always @(negedge clk) begin
        if (!reset && bus_if.snap_valid) begin
            snap_seen++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_snap: snap_valid=1 data_raw=%h required no pulse",
                         bus_if.data_raw);
            end else begin
                chk("snapshot", bus_if.data_raw, exp_q.pop_front());
            end
        end
    end

    initial begin
        reset             = 1'b1;
        vsync             = 1'b1;
        clear             = 1'b0;
        ch_en             = '0;
        ch_down           = '0;
        bus_if.load_valid = 1'b0;
        bus_if.load_ch    = '0;
        bus_if.load_value = '0;
        cycles(3);
        chk("reset_data_raw", bus_if.data_raw, 64'd0);
        chk("reset_snap_valid", 64'(bus_if.snap_valid), 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        reset = 1'b0;
        cycles(2);

        // Four ticks on every channel, counting up.
        run_en(4'hF, 16);
        snap(64'h0004_0004_0004_0004);

        // Up-wrap then down-wrap on channel 3; ovf sticky until clear.
        load(3, 16'hFFFF);
        run_en(4'b1000, 4);
        chk("ovf_after_up_wrap", 64'(ovf), 64'h8);
        snap(64'h0004_0004_0004_0000);
        ch_down = 4'b1000;
        run_en(4'b1000, 4);
        ch_down = '0;
        chk("ovf_after_down_wrap", 64'(ovf), 64'h8);
        snap({48'h0004_0004_0004, MAXV});
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("ovf_after_clear", 64'(ovf), 64'd0);
        chk("data_raw_hold_on_clear", bus_if.data_raw, {48'h0004_0004_0004, MAXV});
        snap(64'h0);

        // Clear aligns the prescaler: ticks land on edges C+4, C+8, ...
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        cycles(3);
        bus_if.load_valid = 1'b1;
        bus_if.load_ch    = 2'd0;
        bus_if.load_value = 16'h0007;
        ch_en             = 4'b0011;
        cyc();
        bus_if.load_valid = 1'b0;
        ch_en             = '0;
        snap(64'h0007_0001_0000_0000);
        clear = 1'b1;
        load(2, 16'h0009);
        clear = 1'b0;
        snap(64'h0);

        // Snapshot edge coincides with a tick: the pre-step value is captured.
        clear = 1'b1;
        cyc();
        clear             = 1'b0;
        bus_if.load_valid = 1'b1;
        bus_if.load_ch    = 2'd0;
        bus_if.load_value = 16'h0005;
        ch_en             = 4'b0001;
        cyc();
        bus_if.load_valid = 1'b0;
        cyc();
        expect_snap(64'h0005_0000_0000_0000);
        vsync = 1'b0;
        cycles(2);
        ch_en = '0;
        vsync = 1'b1;
        cycles(2);
        chk("coincident_snap_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        chk("data_raw_const_mid_frame", bus_if.data_raw, 64'h0005_0000_0000_0000);
        snap(64'h0006_0000_0000_0000);

        // Digit carry/borrow and load sanitising.
        load(0, 16'h0999);
        load(1, 16'h9999);
        load(2, 16'h0000);
        load(3, 16'h00AF);
        ch_down = 4'b0100;
        run_en(4'b0111, 4);
        ch_down = '0;
`ifdef VGA_COUNTER_BANK_BCD_EN
        chk("ovf_mode", 64'(ovf), 64'h6);
        snap(64'h1000_0000_9999_0099);
`else
        chk("ovf_mode", 64'(ovf), 64'h4);
        snap(64'h099A_999A_FFFF_00AF);
`endif

        // Async reset mid-count with vsync low.
        ch_en = 4'hF;
        cycles(2);
        vsync = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk("mid_reset_data_raw", bus_if.data_raw, 64'd0);
        chk("mid_reset_snap_valid", 64'(bus_if.snap_valid), 64'd0);
        chk("mid_reset_ovf", 64'(ovf), 64'd0);
        ch_en = '0;
        cycles(2);
        reset = 1'b0;
        cycles(6);
        vsync = 1'b1;
        cycles(2);
        load(0, 16'h0042);
        snap(64'h0042_0000_0000_0000);

        chk("snap_pulse_count", 64'(snap_seen), 64'(pushed));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
